// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions and transmitter state encoding.
package uart_pkg;

    localparam logic [31:0] TXDATA_OFF = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFF = 32'h0000_0004;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-memory bus as seen by the UART: store strobe, address, data
// and the combinational select/read-data return path.
interface mmio_uart_tx_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sel;
    logic [31:0] rdata;

    modport master (output we, addr, wdata, input sel, rdata);
    modport slave  (input we, addr, wdata, output sel, rdata);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset; full/empty come from the
// registered count so a push while full is refused even if a pop coincides.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register window on the
// core data bus, byte FIFO, and the serialising FSM with its baud counter.
//
//   state | meaning
//   IDLE  | line high, waiting for a buffered byte
//   START | start bit (low) for CLKS_PER_BIT cycles
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high); chains straight into START if more bytes wait
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    mmio_uart_tx_if.slave   bus,
    output logic            tx,
    output logic            busy
);

    localparam int              BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [29:0]     TX_WORD   = BASE_ADDR[31:2] + TXDATA_OFF[31:2];
    localparam logic [29:0]     ST_WORD   = BASE_ADDR[31:2] + STATUS_OFF[31:2];

    logic          hit_tx, hit_st, push, clr_ovf;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;
    logic          unused_bits;

    uart_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic          baud_end;

    assign hit_tx      = (bus.addr[31:2] == TX_WORD);
    assign hit_st      = (bus.addr[31:2] == ST_WORD);
    assign bus.sel     = hit_tx | hit_st;
    assign push        = bus.we & hit_tx;
    assign clr_ovf     = bus.we & hit_st & bus.wdata[ST_OVF];
    assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:8]};

    always_comb begin
        status                            = '0;
        status[ST_FULL]                   = fifo_full;
        status[ST_EMPTY]                  = fifo_empty;
        status[ST_BUSY]                   = busy_q;
        status[ST_OVF]                    = ovf_q;
        status[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(fifo_count);
    end

    assign bus.rdata = hit_st ? status : 32'h0;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (bus.wdata[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = START;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain the next byte without an idle bit time.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE) || !fifo_empty;

        ovf_d = ovf_q;
        if (push && fifo_full) ovf_d = 1'b1;
        else if (clr_ovf)      ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule
